arb_mux2x1: RTL and testbench

ARB_MUX2X1 -- requirements
Module: arb_mux2x1

---
 rtl/arb_pkg.sv | 13 +
 rtl/mux2x1_bus.sv | 13 +
 rtl/arb_mux2x1.sv | 106 ++++++++++
 tb/tb_arb_mux2x1.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester arbitrated mux: FSM encodings and
// the default grant timeout used when ARB_TIMEOUT_EN is defined.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mux2x1_bus.sv
// WIDTH-wide 2:1 bus multiplexer (sel=0 picks a, sel=1 picks b).
module mux2x1_bus #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arb_mux2x1.sv
// Round-robin arbiter granting one of two requesters ownership of a shared mux.
// Define ARB_TIMEOUT_EN to cap each grant at TIMEOUT consecutive cycles.
module arb_mux2x1
  import arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             done0,
  input  logic             done1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("arb_mux2x1: TIMEOUT must be at least 1");
  end

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic       sel_nxt;
  logic       expire;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt, cnt_nxt;

  assign expire = (cnt == CW'(TIMEOUT - 1));

  // Count restarts on every change of owner, including a direct handoff.
  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state && state_nxt != IDLE) cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`else
  assign expire = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) state_nxt = OWN0;
        else if (req1)               state_nxt = OWN1;
      end
      OWN0: begin
        if (done0 || !req0 || expire) begin
          last_nxt  = 1'b0;
          state_nxt = req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (done1 || !req1 || expire) begin
          last_nxt  = 1'b1;
          state_nxt = req0 ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    sel_nxt = (state_nxt == OWN1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      sel   <= sel_nxt;
    end
  end

  assign gnt0    = (state == OWN0);
  assign gnt1    = (state == OWN1);
  assign y_valid = gnt0 | gnt1;

  mux2x1_bus #(.WIDTH(WIDTH)) u_mux (
    .a  (a),
    .b  (b),
    .sel(sel),
    .y  (y)
  );

endmodule

// File: tb/tb_arb_mux2x1.sv
// Directed self-checking bench for arb_mux2x1; timeout expectations follow
// whether ARB_TIMEOUT_EN is defined for the build.
module tb_arb_mux2x1;

  localparam int WIDTH = 8;
  localparam int TOUT  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1, done0, done1;
  logic [WIDTH-1:0] a, b;
  logic             gnt0, gnt1, sel, y_valid;
  logic [WIDTH-1:0] y;

  int n_cmp = 0;
  int n_err = 0;

  arb_mux2x1 #(.WIDTH(WIDTH), .TIMEOUT(TOUT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .done0  (done0),
    .done1  (done1),
    .a      (a),
    .b      (b),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .sel    (sel),
    .y      (y),
    .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic g0, input logic g1);
    check({tag, "_gnt0"}, 32'(gnt0), 32'(g0));
    check({tag, "_gnt1"}, 32'(gnt1), 32'(g1));
    check({tag, "_onehot"}, 32'(gnt0 & gnt1), 32'd0);
  endtask

  initial begin
    int run;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
    a = 8'hA5; b = 8'h3C;

    #3;
    check_grant("rst", 1'b0, 1'b0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_yv", 32'(y_valid), 32'd0);
    check("rst_y", 32'(y), 32'hA5);
    tick();
    rst_n = 1'b1;

    // Single requester, then release by done.
    req0 = 1'b1;
    #1 check("no_comb_gnt0", 32'(gnt0), 32'd0);
    tick();
    check_grant("own0", 1'b1, 1'b0);
    check("own0_sel", 32'(sel), 32'd0);
    check("own0_y", 32'(y), 32'hA5);
    check("own0_yv", 32'(y_valid), 32'd1);
    done0 = 1'b1;
    tick();
    check_grant("done0_idle", 1'b0, 1'b0);
    check("done0_yv", 32'(y_valid), 32'd0);
    done0 = 1'b0; req0 = 1'b0;
    tick();

    // Fresh reset so last=1, then simultaneous requests.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check_grant("both_first", 1'b1, 1'b0);
    done1 = 1'b1;
    tick();
    check_grant("nonowner_done", 1'b1, 1'b0);
    done1 = 1'b0; done0 = 1'b1;
    tick();
    check_grant("handoff1", 1'b0, 1'b1);
    check("handoff1_sel", 32'(sel), 32'd1);
    check("handoff1_y", 32'(y), 32'h3C);
    done0 = 1'b0; done1 = 1'b1;
    tick();
    check_grant("handoff0", 1'b1, 1'b0);
    done1 = 1'b0;

    // Continuous requests, done pulse every third cycle: 0,1,0,1.
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 3; c++) begin
        check_grant($sformatf("rr_g%0d_c%0d", g, c), (g % 2) == 0, (g % 2) == 1);
        if (c == 2) begin
          done0 = (g % 2) == 0;
          done1 = (g % 2) == 1;
        end
        tick();
        done0 = 1'b0; done1 = 1'b0;
      end
    end
    check_grant("rr_end", 1'b1, 1'b0);

    // Asynchronous reset mid-OWN1.
    done0 = 1'b1;
    tick();
    done0 = 1'b0;
    check_grant("pre_arst", 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_grant("arst", 1'b0, 1'b0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_y", 32'(y), 32'hA5);
    check("arst_yv", 32'(y_valid), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    rst_n = 1'b1;
    req1 = 1'b1;
    #1 check("post_rst_no_comb", 32'(gnt1), 32'd0);
    tick();
    check_grant("post_rst_gnt1", 1'b0, 1'b1);
    req1 = 1'b0;
    tick();
    check_grant("req_drop_idle", 1'b0, 1'b0);
    check("idle_sel", 32'(sel), 32'd0);

    // Owner holds on without done while the other requester waits.
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    run = 1;
    while (gnt0 && run < 100) begin
      tick();
      check("hold_onehot", 32'(gnt0 & gnt1), 32'd0);
      if (gnt0) run++;
    end
`ifdef ARB_TIMEOUT_EN
    check("timeout_len", 32'(run), 32'(TOUT));
    check_grant("timeout_next", 1'b0, 1'b1);
`else
    check("hold_len", 32'(run), 32'd100);
    check_grant("hold_still", 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
